zigzag_quant: RTL

ZIGZAG_QUANT -- requirements
Module: zigzag_quant

---
 rtl/zigzag_quant.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/zigzag_quant.sv
// zigzag_quant: 8x8 block buffer that quantizes DCT coefficient rows as they
// arrive, stores them in a ping-pong pair of 64-entry banks, and replays each
// completed block as eight groups of eight coefficients in JPEG zigzag order.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : synchronous active-high reset
//   in_valid  : a row is present on in_data
//   in_data   : 8 signed lanes of COEF_W bits, lane k = column k
//   q_shift   : rounding right-shift amount, captured with row 0 of a block
//   out_valid : out_data carries one zigzag group
//   out_data  : 8 quantized lanes, lane j = zigzag index 8*out_grp+j
//   out_grp   : group number 0..7
//   out_last  : high together with group 7
//   blk_cnt   : blocks fully emitted, wraps

// Per-lane rounding shift: s=0 passes x through, otherwise (x + 2^(s-1)) >>> s
// evaluated one bit wider than the coefficient so the rounding add cannot wrap.
module zigzag_quant_lane #(
  parameter int COEF_W = 12
) (
  input  logic [COEF_W-1:0] x,
  input  logic [2:0]        s,
  output logic [COEF_W-1:0] q
);
  logic signed [COEF_W:0] rnd;
  logic signed [COEF_W:0] sum;
  logic signed [COEF_W:0] shf;

  assign rnd = (COEF_W+1)'(1) << (s - 3'd1);
  assign sum = $signed({x[COEF_W-1], x}) + rnd;
  assign shf = sum >>> s;
  assign q   = (s == 3'd0) ? x : shf[COEF_W-1:0];
endmodule

module zigzag_quant #(
  parameter int COEF_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [8*COEF_W-1:0] in_data,
  input  logic [2:0]          q_shift,
  output logic                out_valid,
  output logic [8*COEF_W-1:0] out_data,
  output logic [2:0]          out_grp,
  output logic                out_last,
  output logic [14:0]         blk_cnt
);
  // Row-major position for each zigzag index.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [2:0] wr_row;
  logic       wr_bank;
  logic [2:0] s_hold;
  logic [2:0] s_cur;
  logic       blk_done;

  logic       rd_active;
  logic [2:0] rd_grp;
  logic       rd_bank;

  logic [7:0][COEF_W-1:0] q_row;
  logic [7:0][COEF_W-1:0] rd_row;

  // Bank 0 occupies entries 0..63, bank 1 entries 64..127.
  logic [COEF_W-1:0] mem [128];

  // Row 0 uses the live shift and latches it; later rows use the latched copy
  // so mid-block changes of q_shift have no effect.
  assign s_cur    = (wr_row == 3'd0) ? q_shift : s_hold;
  assign blk_done = in_valid && (wr_row == 3'd7);

  for (genvar k = 0; k < 8; k++) begin : g_lane
    zigzag_quant_lane #(.COEF_W(COEF_W)) u_lane (
      .x (in_data[k*COEF_W +: COEF_W]),
      .s (s_cur),
      .q (q_row[k])
    );
  end

  always_ff @(posedge clk) begin
    if (in_valid && !reset) begin
      for (int k = 0; k < 8; k++)
        mem[{wr_bank, wr_row, 3'(k)}] <= q_row[k];
    end
  end

  always_comb begin
    rd_row = '0;
    for (int j = 0; j < 8; j++)
      rd_row[j] = mem[{rd_bank, ZZ[{rd_grp, 3'(j)}]}];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_row    <= '0;
      wr_bank   <= 1'b0;
      s_hold    <= '0;
      rd_active <= 1'b0;
      rd_grp    <= '0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_grp   <= '0;
      out_last  <= 1'b0;
      out_data  <= '0;
      blk_cnt   <= '0;
    end else begin
      if (in_valid) begin
        if (wr_row == 3'd0) s_hold <= q_shift;
        wr_row <= wr_row + 3'd1;
        if (wr_row == 3'd7) wr_bank <= ~wr_bank;
      end

      // A new block can only complete on the same edge the previous burst
      // emits group 7, so restarting here keeps bursts gapless.
      if (blk_done) begin
        rd_active <= 1'b1;
        rd_grp    <= '0;
        rd_bank   <= wr_bank;
      end else if (rd_active) begin
        if (rd_grp == 3'd7) rd_active <= 1'b0;
        rd_grp <= rd_grp + 3'd1;
      end

      if (rd_active) begin
        out_valid <= 1'b1;
        out_grp   <= rd_grp;
        out_last  <= (rd_grp == 3'd7);
        out_data  <= rd_row;
      end else begin
        out_valid <= 1'b0;
        out_grp   <= '0;
        out_last  <= 1'b0;
      end

      if (out_valid && out_last) blk_cnt <= blk_cnt + 15'd1;
    end
  end
endmodule
